// File: rtl/pipe_ifid_q.sv
// pipe_ifid_q: 2-entry IF/ID skid queue between fetch and decode.
// Define IFID_BUBBLE_CNT_EN to add the saturating bubble_cnt decode-bubble counter.
module pipe_ifid_q #(
  parameter logic [31:0] NOP_INS = 32'h00000000
) (
  input  logic        clock,
  input  logic        resetn,
  input  logic [31:0] pc4,
  input  logic [31:0] ins,
  input  logic        if_valid,
  output logic        if_ready,
  input  logic        flush,
  input  logic        id_ready,
  output logic        id_valid,
  output logic [31:0] dpc4,
  output logic [31:0] inst
`ifdef IFID_BUBBLE_CNT_EN
  ,
  output logic [15:0] bubble_cnt
`endif
);
  logic [63:0] mem0, mem1, head;
  logic        wp, rp, push, pop;
  logic [1:0]  cnt;
  assign if_ready = cnt != 2'd2;
  assign id_valid = cnt != 2'd0;
  assign push     = if_valid && if_ready && !flush;
  assign pop      = id_valid && id_ready && !flush;
  assign head     = rp ? mem1 : mem0;
  assign inst     = id_valid ? head[31:0] : NOP_INS;
  assign dpc4     = id_valid ? head[63:32] : 32'h0;
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      mem0 <= '0;
      mem1 <= '0;
      wp   <= 1'b0;
      rp   <= 1'b0;
      cnt  <= 2'd0;
    end else if (flush) begin
      wp  <= 1'b0;
      rp  <= 1'b0;
      cnt <= 2'd0;
    end else begin
      if (push && !wp) mem0 <= {pc4, ins};
      if (push && wp) mem1 <= {pc4, ins};
      if (push) wp <= ~wp;
      if (pop) rp <= ~rp;
      cnt <= cnt + 2'(push) - 2'(pop);
    end
  end
`ifdef IFID_BUBBLE_CNT_EN
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) bubble_cnt <= 16'h0;
    else if (id_ready && !id_valid && !flush && bubble_cnt != 16'hFFFF) bubble_cnt <= bubble_cnt + 16'h1;
  end
`endif
endmodule

// File: tb/tb_pipe_ifid_q.sv
// tb_pipe_ifid_q: scoreboard bench for pipe_ifid_q (bubble counter checks under IFID_BUBBLE_CNT_EN).
module tb_pipe_ifid_q;
  localparam logic [31:0] NOP = 32'hFFFF0001;
  logic        clock = 1'b0, resetn = 1'b0;
  logic [31:0] pc4 = '0, ins = '0, dpc4, inst;
  logic        if_valid = 1'b0, if_ready, flush = 1'b0, id_ready = 1'b0, id_valid;
  int          n_cmp = 0, n_bad = 0;
  logic [63:0] q[$];
`ifdef IFID_BUBBLE_CNT_EN
  logic [15:0] bubble_cnt;
  logic [15:0] bub = 16'h0;
`endif

  pipe_ifid_q #(.NOP_INS(NOP)) dut (
    .clock(clock), .resetn(resetn), .pc4(pc4), .ins(ins), .if_valid(if_valid),
    .if_ready(if_ready), .flush(flush), .id_ready(id_ready), .id_valid(id_valid),
    .dpc4(dpc4), .inst(inst)
`ifdef IFID_BUBBLE_CNT_EN
    , .bubble_cnt(bubble_cnt)
`endif
  );

  always #5 clock = ~clock;

  // One cycle from a falling edge: drive, check head against the scoreboard, clock, update model.
  task automatic cyc(input logic v, input logic [31:0] p, input logic [31:0] i, input logic r, input logic f);
    logic do_push, do_pop;
    logic [63:0] exp_head;
    if_valid = v; pc4 = p; ins = i; id_ready = r; flush = f;
    #1;
    exp_head = q.size() != 0 ? q[0] : {32'h0, NOP};
    n_cmp++; if (if_ready !== (q.size() != 2)) begin n_bad++; $display("FAIL if_ready got=%b exp=%b", if_ready, q.size() != 2); end
    n_cmp++; if (id_valid !== (q.size() != 0)) begin n_bad++; $display("FAIL id_valid got=%b exp=%b", id_valid, q.size() != 0); end
    n_cmp++; if (inst !== exp_head[31:0]) begin n_bad++; $display("FAIL inst got=%h exp=%h", inst, exp_head[31:0]); end
    n_cmp++; if (dpc4 !== exp_head[63:32]) begin n_bad++; $display("FAIL dpc4 got=%h exp=%h", dpc4, exp_head[63:32]); end
`ifdef IFID_BUBBLE_CNT_EN
    n_cmp++; if (bubble_cnt !== bub) begin n_bad++; $display("FAIL bubble_cnt got=%h exp=%h", bubble_cnt, bub); end
    if (r && q.size() == 0 && !f && bub != 16'hFFFF) bub++;
`endif
    do_push = v && q.size() < 2 && !f;
    do_pop  = r && q.size() > 0 && !f;
    @(posedge clock);
    if (f) q.delete();
    else begin
      if (do_pop) void'(q.pop_front());
      if (do_push) q.push_back({p, i});
    end
    @(negedge clock);
  endtask

  task automatic test_reset;
    #1;
    n_cmp++; if (id_valid !== 1'b0 || if_ready !== 1'b1) begin n_bad++; $display("FAIL reset_flags got=%b%b exp=01", id_valid, if_ready); end
    n_cmp++; if (inst !== NOP || dpc4 !== 32'h0) begin n_bad++; $display("FAIL reset_head got=%h/%h exp=%h/0", inst, dpc4, NOP); end
    @(negedge clock);
    resetn = 1'b1;
  endtask

  task automatic test_single;
    cyc(1, 32'd4, 32'h20010005, 0, 0);
    n_cmp++; if (id_valid !== 1'b1 || inst !== 32'h20010005 || dpc4 !== 32'd4) begin n_bad++; $display("FAIL single got=%b %h %h exp=1 20010005 4", id_valid, inst, dpc4); end
    cyc(0, 0, 0, 1, 0);
    cyc(0, 0, 0, 0, 0);
  endtask

  task automatic test_fill_drain;
    cyc(1, 32'h100, 32'hAAAA0001, 0, 0);
    cyc(1, 32'h104, 32'hBBBB0002, 0, 0);
    cyc(1, 32'h108, 32'hCCCC0003, 0, 0);
    n_cmp++; if (if_ready !== 1'b0 || inst !== 32'hAAAA0001) begin n_bad++; $display("FAIL full got=%b %h exp=0 aaaa0001", if_ready, inst); end
    cyc(0, 0, 0, 1, 0);
    n_cmp++; if (inst !== 32'hBBBB0002 || dpc4 !== 32'h104) begin n_bad++; $display("FAIL drain_b got=%h %h exp=bbbb0002 104", inst, dpc4); end
    cyc(0, 0, 0, 1, 0);
    cyc(0, 0, 0, 1, 0);
  endtask

  task automatic test_push_pop;
    cyc(1, 32'h200, 32'h11110001, 0, 0);
    cyc(1, 32'h204, 32'h22220002, 1, 0);
    n_cmp++; if (inst !== 32'h22220002 || if_ready !== 1'b1 || id_valid !== 1'b1) begin n_bad++; $display("FAIL push_pop got=%h %b%b exp=22220002 11", inst, if_ready, id_valid); end
    cyc(1, 32'h208, 32'h33330003, 0, 0);
    cyc(1, 32'h20C, 32'h44440004, 1, 0);
    n_cmp++; if (inst !== 32'h33330003 || if_ready !== 1'b1) begin n_bad++; $display("FAIL full_pop_push got=%h %b exp=33330003 1", inst, if_ready); end
    cyc(0, 0, 0, 1, 0);
  endtask

  task automatic test_flush;
    cyc(1, 32'h300, 32'h55550001, 0, 0);
    cyc(1, 32'h304, 32'h66660002, 0, 0);
    cyc(1, 32'h308, 32'h77770003, 1, 1);
    n_cmp++; if (id_valid !== 1'b0 || inst !== NOP || if_ready !== 1'b1) begin n_bad++; $display("FAIL flush got=%b %h %b exp=0 %h 1", id_valid, inst, if_ready, NOP); end
    repeat (3) cyc(1, 32'h30C, 32'h88880004, 1, 1);
    cyc(1, 32'h310, 32'h99990005, 0, 0);
    cyc(0, 0, 0, 1, 0);
  endtask

  task automatic test_async_reset;
    cyc(1, 32'h400, 32'hABCD0001, 0, 0);
    cyc(1, 32'h404, 32'hABCD0002, 0, 0);
    #2 resetn = 1'b0;
    #1;
    n_cmp++; if (id_valid !== 1'b0 || if_ready !== 1'b1) begin n_bad++; $display("FAIL async_reset_flags got=%b%b exp=01", id_valid, if_ready); end
    n_cmp++; if (inst !== NOP || dpc4 !== 32'h0) begin n_bad++; $display("FAIL async_reset_head got=%h %h exp=%h 0", inst, dpc4, NOP); end
    q.delete();
`ifdef IFID_BUBBLE_CNT_EN
    bub = 16'h0;
`endif
    @(negedge clock);
    resetn = 1'b1;
    cyc(1, 32'h500, 32'hFEED0001, 0, 0);
    n_cmp++; if (id_valid !== 1'b1 || inst !== 32'hFEED0001) begin n_bad++; $display("FAIL first_push got=%b %h exp=1 feed0001", id_valid, inst); end
    cyc(0, 0, 0, 1, 0);
  endtask

  task automatic test_back_to_back;
    for (int k = 0; k < 300; k++)
      cyc(1'($urandom_range(0, 3) != 0), $urandom, $urandom, 1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 15) == 0));
    repeat (3) cyc(0, 0, 0, 1, 0);
  endtask

`ifdef IFID_BUBBLE_CNT_EN
  task automatic test_bubble;
    resetn = 1'b0;
    q.delete();
    bub = 16'h0;
    @(negedge clock);
    resetn = 1'b1;
    repeat (3) cyc(0, 0, 0, 1, 0);
    n_cmp++; if (bubble_cnt !== 16'd3) begin n_bad++; $display("FAIL bubble3 got=%h exp=3", bubble_cnt); end
    cyc(0, 0, 0, 1, 1);
    n_cmp++; if (bubble_cnt !== 16'd3) begin n_bad++; $display("FAIL bubble_flush got=%h exp=3", bubble_cnt); end
    repeat (65531) cyc(0, 0, 0, 1, 0);
    n_cmp++; if (bubble_cnt !== 16'hFFFE) begin n_bad++; $display("FAIL bubble_fffe got=%h exp=fffe", bubble_cnt); end
    repeat (5) cyc(0, 0, 0, 1, 0);
    n_cmp++; if (bubble_cnt !== 16'hFFFF) begin n_bad++; $display("FAIL bubble_sat got=%h exp=ffff", bubble_cnt); end
  endtask
`endif

  initial begin
    test_reset;
    test_single;
    test_fill_drain;
    test_push_pop;
    test_flush;
    test_async_reset;
    test_back_to_back;
`ifdef IFID_BUBBLE_CNT_EN
    test_bubble;
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
